// File: rtl/bram_port_master.sv
// Valid/ready command front-end for a single-port block RAM (port A).
// Reads are tracked through the BRAM latency and returned in order through a credit-limited response FIFO.
module bram_port_master #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clka,
   input  logic                  rsta_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_we,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [DATA_W-1:0]     cmd_wdata,
   input  logic [DATA_W/8-1:0]   cmd_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic [ADDR_W-1:0]     addra,
   output logic [DATA_W-1:0]     dina,
   output logic [DATA_W/8-1:0]   wea,
   output logic                  ena,
   input  logic [DATA_W-1:0]     douta
);
   localparam int BE_W  = DATA_W / 8;
   localparam int DEPTH = RD_LATENCY + 2;
   // The output register holds one response, so the skid buffer behind it needs DEPTH-1 slots.
   localparam int IB_N  = DEPTH - 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(IB_N);

   logic                  cmd_ready_q;
   logic [CNT_W-1:0]      inflight_q;
   logic [CNT_W-1:0]      inflight_d;
   logic                  ena_q;
   logic [BE_W-1:0]       wea_q;
   logic [ADDR_W-1:0]     addra_q;
   logic [DATA_W-1:0]     dina_q;
   logic                  rd_issue_q;
   logic [RD_LATENCY-1:0] vld_sr_q;
   logic                  rsp_valid_q;
   logic [DATA_W-1:0]     rsp_rdata_q;
   logic [DATA_W-1:0]     ib_mem_q [IB_N];
   logic [PTR_W-1:0]      ib_rd_q;
   logic [PTR_W-1:0]      ib_wr_q;
   logic [CNT_W-1:0]      ib_cnt_q;

   logic accept_s;
   logic rd_accept_s;
   logic pop_s;
   logic push_s;
   logic load_out_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(IB_N - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   assign accept_s    = cmd_valid && cmd_ready_q;
   assign rd_accept_s = accept_s && !cmd_we;
   assign pop_s       = rsp_valid_q && rsp_ready;
   assign push_s      = vld_sr_q[RD_LATENCY-1];
   assign load_out_s  = !rsp_valid_q || pop_s;

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign addra     = addra_q;
   assign dina      = dina_q;
   assign wea       = wea_q;
   assign ena       = ena_q;

   // Next value of the read credit counter
   always_comb begin
      inflight_d = inflight_q;
      case ({rd_accept_s, pop_s})
         2'b10:   inflight_d = inflight_q + CNT_W'(1);
         2'b01:   inflight_d = inflight_q - CNT_W'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   // Credit counter and registered command-ready
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         inflight_q  <= {CNT_W{1'b0}};
         cmd_ready_q <= 1'b0;
      end else begin
         inflight_q  <= inflight_d;
         cmd_ready_q <= (inflight_d < CNT_W'(DEPTH));
      end
   end

   // BRAM issue stage: one enable pulse per accepted command, address/data hold when idle
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         ena_q   <= 1'b0;
         wea_q   <= {BE_W{1'b0}};
         addra_q <= {ADDR_W{1'b0}};
         dina_q  <= {DATA_W{1'b0}};
      end else if (accept_s) begin
         ena_q   <= 1'b1;
         wea_q   <= cmd_we ? cmd_be : {BE_W{1'b0}};
         addra_q <= cmd_addr;
         dina_q  <= cmd_wdata;
      end else begin
         ena_q   <= 1'b0;
         wea_q   <= {BE_W{1'b0}};
      end
   end

   // Read-valid pipeline aligned so its output marks the cycle douta holds read data
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         rd_issue_q <= 1'b0;
         vld_sr_q   <= {RD_LATENCY{1'b0}};
      end else begin
         rd_issue_q  <= rd_accept_s;
         vld_sr_q[0] <= rd_issue_q;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_sr_q[i] <= vld_sr_q[i-1];
         end
      end
   end

   // Response FIFO: registered head with a skid buffer; douta bypasses straight to the head when empty
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= {DATA_W{1'b0}};
         ib_rd_q     <= {PTR_W{1'b0}};
         ib_wr_q     <= {PTR_W{1'b0}};
         ib_cnt_q    <= {CNT_W{1'b0}};
         for (int i = 0; i < IB_N; i++) begin
            ib_mem_q[i] <= {DATA_W{1'b0}};
         end
      end else if (load_out_s) begin
         if (ib_cnt_q != {CNT_W{1'b0}}) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= ib_mem_q[ib_rd_q];
            ib_rd_q     <= ptr_inc(ib_rd_q);
            if (push_s) begin
               ib_mem_q[ib_wr_q] <= douta;
               ib_wr_q           <= ptr_inc(ib_wr_q);
            end else begin
               ib_cnt_q <= ib_cnt_q - CNT_W'(1);
            end
         end else begin
            rsp_valid_q <= push_s;
            if (push_s) begin
               rsp_rdata_q <= douta;
            end else begin
               rsp_rdata_q <= rsp_rdata_q;
            end
         end
      end else if (push_s) begin
         ib_mem_q[ib_wr_q] <= douta;
         ib_wr_q           <= ptr_inc(ib_wr_q);
         ib_cnt_q          <= ib_cnt_q + CNT_W'(1);
      end else begin
         ib_cnt_q <= ib_cnt_q;
      end
   end

endmodule

// File: tb/tb_bram_port_master.sv
// Scoreboard bench for bram_port_master: BRAM behavioural memory, shadow-memory reference and a response monitor.
module tb_bram_port_master;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int RL = 2;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [BW-1:0] be;
   } cmd_t;

   logic          clka      = 1'b0;
   logic          rsta_n    = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_we    = 1'b0;
   logic [AW-1:0] cmd_addr  = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [BW-1:0] cmd_be    = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] addra;
   logic [DW-1:0] dina;
   logic [BW-1:0] wea;
   logic          ena;
   logic [DW-1:0] douta;

   int            checks = 0;
   int            errors = 0;
   int            cyc    = 0;
   int            acc_cnt = 0;
   logic [DW-1:0] ref_mem [64];
   logic [DW-1:0] exp_q [$];
   int            pop_cyc [$];
   cmd_t          stim_q [$];
   logic [DW-1:0] last_rsp = '0;
   logic          preload = 1'b1;
   bit            rand_done = 1'b0;

   always #5 clka = ~clka;
   always @(posedge clka) cyc <= cyc + 1;

   bram_port_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RL)) dut (
      .clka(clka), .rsta_n(rsta_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .addra(addra), .dina(dina), .wea(wea), .ena(ena), .douta(douta)
   );

   // Block RAM with RL-stage read path
   logic [DW-1:0] bram [64];
   logic [DW-1:0] rd_pipe [RL];
   always @(posedge clka) begin
      if (preload) begin
         for (int i = 0; i < 64; i++) bram[i] <= DW'(i * 4);
      end else if (ena) begin
         for (int b = 0; b < BW; b++)
            if (wea[b]) bram[addra[7:2]][8*b +: 8] <= dina[8*b +: 8];
         rd_pipe[0] <= bram[addra[7:2]];
      end
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign douta = rd_pipe[RL-1];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clka);
      #1;
   endtask

   // Drives queued commands back to back; the reference model is updated at each accept
   task automatic run_stream(input int budget);
      int n = 0;
      int idx;
      while (stim_q.size() != 0 && n < budget) begin
         cmd_valid = 1'b1;
         cmd_we    = stim_q[0].we;
         cmd_addr  = stim_q[0].addr;
         cmd_wdata = stim_q[0].data;
         cmd_be    = stim_q[0].be;
         @(negedge clka);
         if (cmd_ready) begin
            idx = int'(stim_q[0].addr[7:2]);
            if (stim_q[0].we) begin
               for (int b = 0; b < BW; b++)
                  if (stim_q[0].be[b]) ref_mem[idx][8*b +: 8] = stim_q[0].data[8*b +: 8];
            end else begin
               exp_q.push_back(ref_mem[idx]);
            end
            acc_cnt++;
            void'(stim_q.pop_front());
         end
         step();
         n++;
      end
      cmd_valid = 1'b0;
      chk("stream_left", 64'(stim_q.size()), 64'd0);
      stim_q.delete();
   endtask

   task automatic drain(input string nm);
      int w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         step();
         w++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d responses outstanding, expected 0", nm, exp_q.size());
      end
   endtask

   // Response monitor: pops the scoreboard on every handshake and checks hold-while-stalled
   initial begin
      logic          prev_stall;
      logic [DW-1:0] prev_data;
      logic [DW-1:0] e;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clka);
         if (!rsta_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               checks++;
               if (!rsp_valid || rsp_rdata !== prev_data) begin
                  errors++;
                  $display("FAIL rsp_stable: got valid=%0b data=0x%0h, expected valid=1 data=0x%0h",
                           rsp_valid, rsp_rdata, prev_data);
               end
            end
            if (rsp_valid && rsp_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL rsp_spurious: got data=0x%0h, expected no response", rsp_rdata);
               end else begin
                  e = exp_q.pop_front();
                  if (rsp_rdata !== e) begin
                     errors++;
                     $display("FAIL rsp_data: got 0x%0h, expected 0x%0h", rsp_rdata, e);
                  end
               end
               last_rsp = rsp_rdata;
               pop_cyc.push_back(cyc);
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_rdata;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = DW'(i * 4);

      // Reset held with a pending command
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h1234_5678; cmd_be = 4'hF;
      repeat (10) @(posedge clka);
      #1 preload = 1'b0;
      @(negedge clka);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst_ena", 64'(ena), 64'd0);
      chk("rst_wea", 64'(wea), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst_addra", 64'(addra), 64'd0);
      chk("rst_dina", 64'(dina), 64'd0);
      step();
      cmd_valid = 1'b0;
      rsta_n = 1'b1;
      @(negedge clka);
      chk("rel_ready_before_edge", 64'(cmd_ready), 64'd0);
      @(negedge clka);
      chk("rel_ready_after_edge", 64'(cmd_ready), 64'd1);
      step();

      // Back-pressure: 8 reads with rsp_ready low, only DEPTH may be accepted
      rsp_ready = 1'b0;
      acc_cnt = 0;
      for (int i = 0; i < 8; i++) stim_q.push_back('{1'b0, AW'(i * 4), DW'(0), BW'(0)});
      fork
         run_stream(300);
         begin
            repeat (20) @(negedge clka);
            chk("bp_accepts", 64'(acc_cnt), 64'(RL + 2));
            chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("bp_ena_idle", 64'(ena), 64'd0);
            pop_cyc.delete();
            step();
            rsp_ready = 1'b1;
         end
      join
      drain("bp");
      chk("bp_resp_count", 64'(pop_cyc.size()), 64'd8);
      if (pop_cyc.size() == 8) begin
         chk("bp_rate_first4", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);
         chk("bp_rate_last4", 64'(pop_cyc[7] - pop_cyc[4]), 64'd3);
      end
      chk("bp_last_data", 64'(last_rsp), 64'h1C);

      // Full write then read of addr 0, with BRAM port and latency checks
      step();
      stim_q.push_back('{1'b1, 32'h0, 32'h5555_5555, 4'hF});
      run_stream(50);
      @(negedge clka);
      chk("wr_ena", 64'(ena), 64'd1);
      chk("wr_wea", 64'(wea), 64'hF);
      chk("wr_addra", 64'(addra), 64'h0);
      chk("wr_dina", 64'(dina), 64'h5555_5555);
      step();
      stim_q.push_back('{1'b0, 32'h0, 32'h0, 4'h0});
      run_stream(50);
      for (int k = 0; k <= RL; k++) begin
         @(negedge clka);
         if (k == 0) begin
            chk("rd_ena", 64'(ena), 64'd1);
            chk("rd_wea", 64'(wea), 64'd0);
         end
         if (k == 1) chk("rd_ena_drop", 64'(ena), 64'd0);
         chk("rd_lat_early", 64'(rsp_valid), 64'd0);
         step();
      end
      @(negedge clka);
      chk("rd_lat_valid", 64'(rsp_valid), 64'd1);
      chk("rd_lat_data", 64'(rsp_rdata), 64'h5555_5555);
      step();
      drain("wr_rd");

      // Partial write with read-after-write back to back
      stim_q.push_back('{1'b1, 32'h4, 32'h5555_5555, 4'hF});
      stim_q.push_back('{1'b1, 32'h4, 32'hAAAA_AAAA, 4'h3});
      stim_q.push_back('{1'b0, 32'h4, 32'h0, 4'h0});
      run_stream(50);
      drain("partial");
      chk("partial_data", 64'(last_rsp), 64'h5555_AAAA);

      // Reset with reads still in flight
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) stim_q.push_back('{1'b0, AW'(8 + i * 4), DW'(0), BW'(0)});
      run_stream(50);
      rsta_n = 1'b0;
      @(negedge clka);
      chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
      step();
      rsta_n = 1'b1;
      rsp_ready = 1'b1;
      pop_cyc.delete();
      repeat (12) step();
      chk("mid_rst_no_rsp", 64'(pop_cyc.size()), 64'd0);
      stim_q.push_back('{1'b0, 32'h8, 32'h0, 4'h0});
      run_stream(50);
      drain("post_rst");
      chk("post_rst_data", 64'(last_rsp), 64'h8);

      // Random mix against the shadow memory with random response back-pressure
      for (int i = 0; i < 300; i++)
         stim_q.push_back('{1'($urandom_range(0, 1)), AW'($urandom_range(0, 15) * 4),
                            DW'($urandom()), BW'($urandom_range(0, 15))});
      fork
         begin
            run_stream(5000);
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               rsp_ready = 1'($urandom_range(0, 1));
               step();
            end
         end
      join
      rsp_ready = 1'b1;
      drain("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bram_port_master.md
# bram_port_master

- Initiator for the single-port block-RAM port A interface: addra, dina, wea, ena, douta.
- Accepts read/write commands on a valid/ready stream and drives the BRAM port with registered signals.
- Tracks read latency and returns read data in order on a valid/ready response stream, buffered so that response back-pressure never loses data.
- Sits between any on-chip requester (sequencer, DMA, register bridge) and a design_1-style BRAM wrapper.

## Interface
Parameters:
- ADDR_W, 32, width of addra / cmd_addr
- DATA_W, 32, width of data buses; must be a multiple of 8
- RD_LATENCY, 1, BRAM clock edges from ena sample to valid douta (1 = no output register, 2 = output register); legal range 1..4

Ports:
- clka  in  1  sole clock, rising edge
- rsta_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a clka edge
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  address, passed unmodified to addra
- cmd_wdata  in  DATA_W  write data
- cmd_be  in  DATA_W/8  byte enables for writes; ignored on reads
- rsp_valid  out  1  read data available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a clka edge
- rsp_rdata  out  DATA_W  read data
- addra  out  ADDR_W  BRAM address
- dina  out  DATA_W  BRAM write data
- wea  out  DATA_W/8  BRAM byte write enables
- ena  out  1  BRAM port enable
- douta  in  DATA_W  BRAM read data

## Operation
Issue stage (all BRAM outputs registered):
- Accepted command at edge E sets ena=1 for exactly the cycle E..E+1, with addra=cmd_addr and dina=cmd_wdata.
- wea=cmd_be for a write, 4'b0000-equivalent (all zero) for a read.
- No accept at E: ena=0, wea=0; addra and dina hold their last values.

Read tracking:
- A RD_LATENCY-deep valid shift register is loaded with 1 for each issued read and 0 otherwise.
- When its output is 1, douta is pushed into the response FIFO.
- Writes never produce a response.

Response FIFO:
- Depth D = RD_LATENCY+2; first-word registered output on rsp_valid/rsp_rdata.
- Responses are strictly in command order.

Credit counter `inflight` (0..D):
- Counts reads accepted but not yet popped from the FIFO.
- Increments on read accept, decrements on response pop; both in the same edge leaves it unchanged.

Flow control:
- cmd_ready = (inflight < D) && out of reset; identical for reads and writes.
- Once inflight == D, a pop in cycle k raises cmd_ready in cycle k+1, giving a sustained 1 accept/cycle when rsp_ready stays 1.

Invariants:
- FIFO never overflows.
- rsp_valid/rsp_rdata stay stable while rsp_valid && !rsp_ready.

## Timing
Reset (rsta_n low, asynchronous, takes effect immediately):
- cmd_ready=0, rsp_valid=0, rsp_rdata=0, ena=0, wea=0, addra=0, dina=0.
- FIFO empty, inflight=0, shift register cleared.
- cmd_ready=1 from the first edge after rsta_n rises.

Read latency:
- Read accepted at edge E; ena high E..E+1; douta valid after edge E+RD_LATENCY; captured at edge E+RD_LATENCY+1; rsp_valid high from that edge.
- Accept-to-response is RD_LATENCY+1 edges (2 for RD_LATENCY=1).

Write latency:
- Write accepted at E; memory updated at edge E+1.
- A read accepted at E+1 to the same address returns the new data (read-after-write needs no stall).

Boundary conditions:
- Reset mid-operation: in-flight reads and buffered responses are discarded; no response is ever produced for them.
- FIFO full with rsp_ready=0: cmd_ready=0; the BRAM idles with ena=0.

## Test plan
- Reset: hold rsta_n=0 for 10 cycles with cmd_valid=1 -> cmd_ready=0, ena=0, wea=0, rsp_valid=0; cmd_ready=1 one edge after release.
- Write/read, RD_LATENCY=1: write addr 0x0, data 0x55555555, be=0xF; then read addr 0x0 -> ena pulses one cycle each, wea=0xF then 0x0, rsp_rdata=0x55555555 with rsp_valid 2 edges after the read accept.
- Partial write: write 0xAAAAAAAA with be=0x3 over 0x55555555 at addr 0x4; read back -> 0x5555AAAA.
- Back-pressure, RD_LATENCY=2 (D=4): rsp_ready=0, issue 8 reads to addrs 0x0..0x1C holding value=addr -> exactly 4 accepted, cmd_ready stays 0.
- Back-pressure continued: raise rsp_ready -> 8 responses in address order, no loss or duplicates, 1 response/cycle at steady state.
- Mid-flight reset: 3 reads outstanding, pulse rsta_n low for 1 cycle -> no rsp_valid afterwards; the next read returns correct data.
